// File: rtl/ram1_bus_pkg.sv
// Shared definitions for the RAM1 data-bus arbiter.
// Holds the requester IDs, the transaction state encoding, the idle levels of
// every active-low pin, and helpers that map a state to its pin levels and a
// one-hot grant to a requester ID.
package ram1_bus_pkg;

    localparam int RAM1_AW = 18;
    localparam int RAM1_DW = 16;

    // Requester IDs; also the encoding of the round-robin pointer.
    typedef enum logic [1:0] {
        REQ_MEM = 2'd0,
        REQ_TX  = 2'd1,
        REQ_RX  = 2'd2
    } req_id_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_MEM_RD0 = 4'd1,
        ST_MEM_RD1 = 4'd2,
        ST_MEM_WR0 = 4'd3,
        ST_MEM_WR1 = 4'd4,
        ST_TX_WR   = 4'd5,
        ST_TX_HOLD = 4'd6,
        ST_TX_TBRE = 4'd7,
        ST_TX_TSRE = 4'd8,
        ST_RX_RD0  = 4'd9,
        ST_RX_RD1  = 4'd10
    } state_e;

    // Pin levels owned by the arbiter; drive=1 means the arbiter drives ram1_data.
    typedef struct packed {
        logic en;
        logic oe;
        logic we;
        logic rdn;
        logic wrn;
        logic drive;
    } pins_t;

    localparam pins_t PINS_IDLE = '{en: 1'b1, oe: 1'b1, we: 1'b1,
                                    rdn: 1'b1, wrn: 1'b1, drive: 1'b0};

    // Pin levels that must be present while the FSM sits in a given state.
    function automatic pins_t pins_for(input state_e st);
        pins_t p;
        p = PINS_IDLE;
        case (st)
            ST_MEM_RD0, ST_MEM_RD1: begin
                p.en = 1'b0;
                p.oe = 1'b0;
            end
            ST_MEM_WR0: begin
                p.en    = 1'b0;
                p.we    = 1'b0;
                p.drive = 1'b1;
            end
            ST_MEM_WR1: begin
                p.en    = 1'b0;
                p.drive = 1'b1;
            end
            ST_TX_WR: begin
                p.wrn   = 1'b0;
                p.drive = 1'b1;
            end
            ST_TX_HOLD: p.drive = 1'b1;
            ST_RX_RD0, ST_RX_RD1: p.rdn = 1'b0;
            default: p = PINS_IDLE;
        endcase
        return p;
    endfunction

    // Converts a one-hot grant into a requester ID (only called with a grant present).
    function automatic req_id_e grant_to_id(input logic [2:0] grant);
        req_id_e id;
        case (grant)
            3'b001:  id = REQ_MEM;
            3'b010:  id = REQ_TX;
            default: id = REQ_RX;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter, purely combinational.
// Ports:
//   req   - request vector, bit index = requester ID (MEM=0, TX=1, RX=2)
//   last  - ID of the most recently granted requester (pointer held by parent)
//   grant - one-hot grant; the search starts at the requester after 'last'
module rr_arbiter3
    import ram1_bus_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_e    last,
    output logic [2:0] grant
);

    // Priority search in MEM->TX->RX order rotated to begin after the last winner.
    always_comb begin
        grant = 3'b000;
        case (last)
            REQ_MEM: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            REQ_TX: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/ram1_bus_arbiter.sv
// Owner of the shared RAM1 data bus, used by both the RAM1 chip and the CPLD
// UART. Arbitrates between memory access, UART transmit and UART receive and
// walks each granted transaction through its pin handshake so that only one
// agent ever drives or samples the bus. All state changes on the falling edge
// of clk; every pin and pulse is registered.
// Ports:
//   clk, rst                       - clock (falling-edge), async active-low reset
//   mem_req/we/addr/wdata          - memory request (level, held until mem_done)
//   mem_rdata, mem_done            - read data and one-cycle completion pulse
//   tx_req, tx_data, tx_done       - UART send request, byte, completion pulse
//   rx_req, rx_avail, rx_data, rx_valid - UART receive handshake
//   tbre, tsre, data_ready         - CPLD UART status
//   rdn, wrn                       - CPLD UART strobes (active-low)
//   ram1_addr, ram1_data           - RAM1 address and shared data bus
//   ram1_en, ram1_oe, ram1_we      - RAM1 controls (active-low)
module ram1_bus_arbiter
    import ram1_bus_pkg::*;
#(
    parameter int AW = RAM1_AW,
    parameter int DW = RAM1_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    input  logic          tx_req,
    input  logic [7:0]    tx_data,
    output logic          tx_done,
    input  logic          rx_req,
    output logic          rx_avail,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          tbre,
    input  logic          tsre,
    input  logic          data_ready,
    output logic          rdn,
    output logic          wrn,
    output logic [AW-1:0] ram1_addr,
    inout  wire  [DW-1:0] ram1_data,
    output logic          ram1_en,
    output logic          ram1_oe,
    output logic          ram1_we
);

    state_e        state_r;
    state_e        state_nxt_s;
    req_id_e       last_r;
    pins_t         pins_r;
    logic [DW-1:0] bus_data_r;
    logic [AW-1:0] ram1_addr_r;
    logic [DW-1:0] mem_rdata_r;
    logic [7:0]    rx_data_r;
    logic          mem_done_r;
    logic          tx_done_r;
    logic          rx_valid_r;
    logic          rx_avail_r;
    logic [2:0]    req_s;
    logic [2:0]    grant_s;
    logic          bus_drive_s;

    // A requester whose completion pulse is showing is still dropping its
    // level request, so it is masked for that one cycle to avoid a regrant.
    always_comb begin
        req_s    = 3'b000;
        req_s[0] = mem_req & ~mem_done_r;
        req_s[1] = tx_req & ~tx_done_r;
        req_s[2] = rx_req & data_ready & ~rx_valid_r;
    end

    rr_arbiter3 u_rr (
        .req   (req_s),
        .last  (last_r),
        .grant (grant_s)
    );

    // Next-state logic of the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s[0])      state_nxt_s = mem_we ? ST_MEM_WR0 : ST_MEM_RD0;
                else if (grant_s[1]) state_nxt_s = ST_TX_WR;
                else if (grant_s[2]) state_nxt_s = ST_RX_RD0;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_MEM_RD0: state_nxt_s = ST_MEM_RD1;
            ST_MEM_RD1: state_nxt_s = ST_IDLE;
            ST_MEM_WR0: state_nxt_s = ST_MEM_WR1;
            ST_MEM_WR1: state_nxt_s = ST_IDLE;
            ST_TX_WR:   state_nxt_s = ST_TX_HOLD;
            ST_TX_HOLD: state_nxt_s = ST_TX_TBRE;
            ST_TX_TBRE: begin
                if (tbre) state_nxt_s = ST_TX_TSRE;
                else      state_nxt_s = ST_TX_TBRE;
            end
            ST_TX_TSRE: begin
                if (tsre) state_nxt_s = ST_IDLE;
                else      state_nxt_s = ST_TX_TSRE;
            end
            ST_RX_RD0:  state_nxt_s = ST_RX_RD1;
            ST_RX_RD1:  state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state, registered pins, grant latches, captures and pulses.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            last_r      <= REQ_RX;
            pins_r      <= PINS_IDLE;
            bus_data_r  <= {DW{1'b0}};
            ram1_addr_r <= {AW{1'b0}};
            mem_rdata_r <= {DW{1'b0}};
            rx_data_r   <= 8'h00;
            mem_done_r  <= 1'b0;
            tx_done_r   <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_avail_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            // Pins follow the state being entered, so they are valid for its whole cycle.
            pins_r     <= pins_for(state_nxt_s);
            rx_avail_r <= data_ready;
            mem_done_r <= (state_r == ST_MEM_RD1) || (state_r == ST_MEM_WR1);
            tx_done_r  <= (state_r == ST_TX_TSRE) && tsre;
            rx_valid_r <= (state_r == ST_RX_RD1);

            // Sampled before oe/rdn are released on this same edge.
            if (state_r == ST_MEM_RD1) begin
                mem_rdata_r <= ram1_data;
            end
            if (state_r == ST_RX_RD1) begin
                rx_data_r <= ram1_data[7:0];
            end

            // Grant: move the pointer and latch the winner's operands.
            if ((state_r == ST_IDLE) && (grant_s != 3'b000)) begin
                last_r <= grant_to_id(grant_s);
                if (grant_s[0]) begin
                    ram1_addr_r <= mem_addr;
                    bus_data_r  <= mem_wdata;
                end else if (grant_s[1]) begin
                    bus_data_r  <= {{(DW-8){1'b0}}, tx_data};
                end
            end
        end
    end

    assign bus_drive_s = pins_r.drive;
    assign ram1_data   = bus_drive_s ? bus_data_r : {DW{1'bz}};
    assign ram1_addr   = ram1_addr_r;
    assign ram1_en     = pins_r.en;
    assign ram1_oe     = pins_r.oe;
    assign ram1_we     = pins_r.we;
    assign rdn         = pins_r.rdn;
    assign wrn         = pins_r.wrn;
    assign mem_rdata   = mem_rdata_r;
    assign mem_done    = mem_done_r;
    assign tx_done     = tx_done_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign rx_avail    = rx_avail_r;

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Directed bench for ram1_bus_arbiter. The DUT acts on falling clock edges;
// the bench samples and drives at rising edges. A RAM1 model drives the bus
// while en=0 and oe=0, a CPLD model drives the low byte while rdn=0.
module tb_ram1_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_req, rx_avail, rx_valid;
    logic [7:0]  rx_data;
    logic        tbre, tsre, data_ready;
    logic        rdn, wrn;
    logic [17:0] ram1_addr;
    wire  [15:0] ram1_data;
    logic        ram1_en, ram1_oe, ram1_we;

    logic [15:0] mem_q;
    logic [7:0]  cpld_q;
    int          checks = 0;
    int          errors = 0;

    assign ram1_data = (!ram1_en && !ram1_oe) ? mem_q :
                       (!rdn)                 ? {8'h00, cpld_q} : 16'hzzzz;

    always #5 clk = ~clk;

    ram1_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
        .rx_req(rx_req), .rx_avail(rx_avail), .rx_data(rx_data), .rx_valid(rx_valid),
        .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
        .rdn(rdn), .wrn(wrn), .ram1_addr(ram1_addr), .ram1_data(ram1_data),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
    endtask

    // Concatenated idle pin view {en,oe,we,rdn,wrn,drive}.
    function automatic logic [5:0] pins();
        return {ram1_en, ram1_oe, ram1_we, rdn, wrn, dut.bus_drive_s};
    endfunction

    initial begin
        rst = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 18'h0; mem_wdata = 16'h0;
        tx_req = 1'b0; tx_data = 8'h00; rx_req = 1'b0;
        tbre = 1'b0; tsre = 1'b0; data_ready = 1'b0;
        mem_q = 16'h0000; cpld_q = 8'h00;
        #2 rst = 1'b0;
        step();
        // ---- reset state
        check("rst_pins", {26'd0, pins()}, {26'd0, 6'b111110});
        check("rst_addr", {14'd0, ram1_addr}, 32'h0);
        check("rst_pulses", {29'd0, mem_done, tx_done, rx_valid}, 32'h0);
        check("rst_rdata", {16'd0, mem_rdata}, 32'h0);
        check("rst_rx", {23'd0, rx_avail, rx_data}, 32'h0);
        rst = 1'b1;

        // ---- memory write 0x00010 <- 0xBEEF
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00010; mem_wdata = 16'hBEEF;
        step();
        check("wr0_pins", {26'd0, pins()}, {26'd0, 6'b010111});
        check("wr0_bus", {16'd0, ram1_data}, 32'hBEEF);
        check("wr0_addr", {14'd0, ram1_addr}, 32'h00010);
        mem_wdata = 16'h1234; mem_addr = 18'h3FFFF;
        step();
        check("wr1_pins", {26'd0, pins()}, {26'd0, 6'b011111});
        check("wr1_bus", {16'd0, ram1_data}, 32'hBEEF);
        check("wr1_addr", {14'd0, ram1_addr}, 32'h00010);
        check("wr1_nodone", {31'd0, mem_done}, 32'h0);
        step();
        check("wr_done", {31'd0, mem_done}, 32'h1);
        check("wr_idle", {26'd0, pins()}, {26'd0, 6'b111110});
        mem_req = 1'b0;
        step();
        check("wr_done_1cyc", {31'd0, mem_done}, 32'h0);

        // ---- memory read 0x00010, model returns 0xBEEF
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00010; mem_q = 16'hBEEF;
        step();
        check("rd0_pins", {26'd0, pins()}, {26'd0, 6'b001110});
        check("rd0_bus", {16'd0, ram1_data}, 32'hBEEF);
        step();
        check("rd1_pins", {26'd0, pins()}, {26'd0, 6'b001110});
        check("rd1_nodone", {31'd0, mem_done}, 32'h0);
        step();
        check("rd_done", {31'd0, mem_done}, 32'h1);
        check("rd_data", {16'd0, mem_rdata}, 32'hBEEF);
        mem_req = 1'b0; mem_q = 16'h0000;
        step();
        check("rd_done_1cyc", {31'd0, mem_done}, 32'h0);
        check("rd_data_hold", {16'd0, mem_rdata}, 32'hBEEF);

        // ---- UART transmit 0x5A
        tx_req = 1'b1; tx_data = 8'h5A;
        step();
        check("tx_wr_pins", {26'd0, pins()}, {26'd0, 6'b111101});
        check("tx_wr_bus", {16'd0, ram1_data}, 32'h005A);
        tx_data = 8'hFF;
        step();
        check("tx_hold_pins", {26'd0, pins()}, {26'd0, 6'b111111});
        check("tx_hold_bus", {16'd0, ram1_data}, 32'h005A);
        step();
        check("tx_tbre_pins", {26'd0, pins()}, {26'd0, 6'b111110});
        step();
        check("tx_tbre_wait", {26'd0, pins()}, {26'd0, 6'b111110});
        tbre = 1'b1;
        step();
        check("tx_tsre_nodone", {31'd0, tx_done}, 32'h0);
        step();
        check("tx_tsre_wait", {31'd0, tx_done}, 32'h0);
        tsre = 1'b1;
        step();
        check("tx_done", {31'd0, tx_done}, 32'h1);
        check("tx_en_high", {31'd0, ram1_en}, 32'h1);
        tx_req = 1'b0; tbre = 1'b0; tsre = 1'b0;
        step();
        check("tx_done_1cyc", {31'd0, tx_done}, 32'h0);

        // ---- UART receive, CPLD presents 0xA5
        data_ready = 1'b1; rx_req = 1'b1; cpld_q = 8'hA5;
        step();
        check("rx0_pins", {26'd0, pins()}, {26'd0, 6'b111010});
        check("rx0_avail", {31'd0, rx_avail}, 32'h1);
        step();
        check("rx1_pins", {26'd0, pins()}, {26'd0, 6'b111010});
        check("rx1_novalid", {31'd0, rx_valid}, 32'h0);
        step();
        check("rx_valid", {31'd0, rx_valid}, 32'h1);
        check("rx_data", {24'd0, rx_data}, 32'hA5);
        check("rx_rdn_high", {31'd0, rdn}, 32'h1);
        rx_req = 1'b0; data_ready = 1'b0;
        step();
        check("rx_valid_1cyc", {31'd0, rx_valid}, 32'h0);
        check("rx_avail_low", {31'd0, rx_avail}, 32'h0);

        // ---- round robin with all three held from reset
        #1 rst = 1'b0;
        #1 check("rr_rst_pins", {26'd0, pins()}, {26'd0, 6'b111110});
        step();
        rst = 1'b1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00020; mem_q = 16'h1111;
        tx_req = 1'b1; tx_data = 8'h33; tbre = 1'b1; tsre = 1'b1;
        rx_req = 1'b1; data_ready = 1'b1; cpld_q = 8'h44;
        step();
        check("rr_g1_mem", {26'd0, pins()}, {26'd0, 6'b001110});
        step();
        step();
        check("rr_mem_done", {31'd0, mem_done}, 32'h1);
        check("rr_mem_data", {16'd0, mem_rdata}, 32'h1111);
        step();
        check("rr_g2_tx", {26'd0, pins()}, {26'd0, 6'b111101});
        step(); step(); step(); step();
        check("rr_tx_done", {31'd0, tx_done}, 32'h1);
        step();
        check("rr_g3_rx", {26'd0, pins()}, {26'd0, 6'b111010});
        step(); step();
        check("rr_rx_valid", {31'd0, rx_valid}, 32'h1);
        check("rr_rx_data", {24'd0, rx_data}, 32'h44);
        step();
        check("rr_g4_mem", {26'd0, pins()}, {26'd0, 6'b001110});

        // ---- reset while TX waits for tbre
        mem_req = 1'b0; rx_req = 1'b0; data_ready = 1'b0;
        tbre = 1'b0; tsre = 1'b0;
        step(); step();
        check("ab_mem_done", {31'd0, mem_done}, 32'h1);
        step();
        check("ab_tx_wr", {26'd0, pins()}, {26'd0, 6'b111101});
        step(); step(); step();
        check("ab_in_tbre", {26'd0, pins()}, {26'd0, 6'b111110});
        mem_req = 1'b1;
        #1 rst = 1'b0;
        #1 check("ab_rst_pins", {26'd0, pins()}, {26'd0, 6'b111110});
        tbre = 1'b1; tsre = 1'b1;
        step();
        check("ab_no_done", {31'd0, tx_done}, 32'h0);
        rst = 1'b1;
        step();
        check("ab_first_mem", {26'd0, pins()}, {26'd0, 6'b001110});
        check("ab_no_done2", {31'd0, tx_done}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram1_bus_arbiter.md
Name: ram1_bus_arbiter

Overview:
Owns the shared RAM1 data bus, which the RAM1 chip and the CPLD UART (rdn/wrn, tbre/tsre/data_ready) both use. Arbitrates among three requesters: memory access, UART transmit and UART receive. Sequences each granted transaction through the correct pin handshake, so no two agents ever drive or sample the bus at once. Sits between the CPU memory/IO stage and the board pins.

Parameters:
AW, 18, RAM1 address width
DW, 16, RAM1 data width; UART uses bits [7:0]

Ports:
clk  in  1  system clock; all state updates on falling edge, as elsewhere in the codebase
rst  in  1  reset, asynchronous, active-low
mem_req  in  1  memory request, level, held until mem_done
mem_we  in  1  1=write, 0=read
mem_addr  in  AW  memory address
mem_wdata  in  DW  write data
mem_rdata  out  DW  read data, valid with mem_done
mem_done  out  1  one-cycle completion pulse
tx_req  in  1  UART send request, level, held until tx_done
tx_data  in  8  byte to send
tx_done  out  1  one-cycle pulse once tsre seen
rx_req  in  1  consumer ready to take a byte
rx_avail  out  1  registered copy of data_ready
rx_data  out  8  received byte, valid with rx_valid
rx_valid  out  1  one-cycle pulse
tbre, tsre, data_ready  in  1  CPLD status
rdn, wrn  out  1  CPLD strobes, active-low
ram1_addr  out  AW  RAM1 address
ram1_data  inout  DW  shared bus
ram1_en, ram1_oe, ram1_we  out  1  RAM1 controls, active-low

Behaviour:
- Reset (async, rst=0): state IDLE; rdn=wrn=ram1_en=ram1_oe=ram1_we=1; ram1_data=Z; ram1_addr=0; all pulses 0; mem_rdata=0; rx_data=0; rx_avail=0; RR pointer=RX, so MEM has first priority. Reset mid-transaction aborts it with no done pulse.
- Eligibility in IDLE: MEM if mem_req; TX if tx_req; RX if rx_req && data_ready.
- Round-robin order is MEM→TX→RX. The search starts after the last granted requester, and the pointer updates on grant.
- Grant latches mem_we/mem_addr/mem_wdata/tx_data. Inputs may change after grant. A request dropped before grant is ignored. A granted transaction always completes.
- Bus drive: ram1_data[DW-1:0] is driven only in MEM_WR0/MEM_WR1 (mem data) and TX_WR/TX_HOLD ({zeros, tx byte}); it is Z otherwise. Bus is never driven while ram1_oe=0 or rdn=0.
- During UART states ram1_en=1. During MEM states rdn=wrn=1.
- States and transitions (one clk each unless noted):
  IDLE → grant target, or stay.
  MEM_RD0: en=0, oe=0, addr driven → MEM_RD1.
  MEM_RD1: same pins; capture ram1_data into mem_rdata; mem_done=1 → IDLE.
  MEM_WR0: en=0, we=0, addr+data driven → MEM_WR1.
  MEM_WR1: we=1, addr+data held; mem_done=1 → IDLE.
  TX_WR: wrn=0, data driven → TX_HOLD.
  TX_HOLD: wrn=1, data held → TX_TBRE.
  TX_TBRE: wait tbre=1 → TX_TSRE.
  TX_TSRE: wait tsre=1; on exit tx_done=1 → IDLE.
  RX_RD0: rdn=0 → RX_RD1.
  RX_RD1: rdn=0; capture ram1_data[7:0] into rx_data; rx_valid=1 → IDLE (rdn=1).
- Latency: memory read/write is 2 cycles grant-to-done plus 1 cycle IDLE. TX takes at least 4 cycles; RX takes 2.
- Done/valid pulses are registered and last exactly one cycle. A requester may reassert in the cycle after its pulse.
- tbre/tsre wait indefinitely; there is no timeout, and other requesters stall meanwhile.
- mem_rdata and rx_data hold their value until the next capture.

Decomposition:
- Package ram1_bus_pkg: state encodings, requester IDs (REQ_MEM=0, REQ_TX=1, REQ_RX=2), idle pin levels.
- Sub-module rr_arbiter3: 3-bit request plus last-grant pointer → one-hot grant, combinational. Pointer register stays in parent.

Test Plan:
- Reset then mem write addr 0x00010, data 0xBEEF → en=0 for 2 cycles, we=0 in 1st only, bus=0xBEEF both cycles, mem_done one pulse.
- Mem read addr 0x00010 with model returning 0xBEEF → oe=0 for 2 cycles, bus Z, mem_rdata=0xBEEF with mem_done.
- tx_req byte 0x5A; tbre rises after 3 cycles, tsre 2 later → wrn low exactly 1 cycle, bus[7:0]=0x5A for 2 cycles, tx_done one cycle after tsre, ram1_en=1 throughout.
- data_ready=1, rx_req=1, CPLD drives 0xA5 → rdn low 2 cycles, rx_data=0xA5 with rx_valid, bus never driven by DUT.
- mem_req, tx_req and RX eligible at once from reset → grant order MEM, TX, RX, then MEM again with all held.
- Assert rst while in TX_TBRE → immediately wrn=rdn=1, bus Z; no tx_done; first grant after release is MEM.
